// File: rtl/tl_ul_sram_slave.sv
// TileLink-UL memory target: byte-masked single-word Get/Put access to an
// internal synchronous SRAM. In-order responses return through a credit-limited
// response FIFO.
module tl_ul_sram_slave #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           SIZE_WIDTH = 3,
    parameter int unsigned           SRC_WIDTH  = 2,
    parameter int unsigned           SINK_WIDTH = 1,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned           MEM_WORDS  = 1024,
    parameter int unsigned           RSP_DEPTH  = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [2:0]              a_opcode,
    input  logic [2:0]              a_param,
    input  logic [SIZE_WIDTH-1:0]   a_size,
    input  logic [SRC_WIDTH-1:0]    a_source,
    input  logic [ADDR_WIDTH-1:0]   a_address,
    input  logic [DATA_WIDTH/8-1:0] a_mask,
    input  logic [DATA_WIDTH-1:0]   a_data,
    output logic                    d_valid,
    input  logic                    d_ready,
    output logic [2:0]              d_opcode,
    output logic [2:0]              d_param,
    output logic [SIZE_WIDTH-1:0]   d_size,
    output logic [SRC_WIDTH-1:0]    d_source,
    output logic [SINK_WIDTH-1:0]   d_sink,
    output logic [DATA_WIDTH-1:0]   d_data,
    output logic                    d_error,
    output logic [15:0]             err_count
);

    localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned OFF_W      = $clog2(MASK_WIDTH);
    localparam int unsigned IDX_W      = $clog2(MEM_WORDS);
    localparam int unsigned CNT_W      = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PTR_W      = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_WORDS * MASK_WIDTH);

    localparam logic [2:0] OP_PUT_FULL = 3'd0;
    localparam logic [2:0] OP_PUT_PART = 3'd1;
    localparam logic [2:0] OP_GET      = 3'd4;

    typedef struct packed {
        logic [2:0]            opcode;
        logic [SIZE_WIDTH-1:0] size;
        logic [SRC_WIDTH-1:0]  source;
        logic [DATA_WIDTH-1:0] data;
        logic                  error;
    } rsp_t;

    logic                  accept;
    logic                  op_put;
    logic                  op_get;
    logic                  req_err;
    logic [ADDR_WIDTH-1:0] offset;
    logic [IDX_W-1:0]      word_idx;
    logic [OFF_W-1:0]      align_mask;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic                  s1_valid;
    logic                  s1_get;
    logic                  s1_err;
    logic [SIZE_WIDTH-1:0] s1_size;
    logic [SRC_WIDTH-1:0]  s1_source;
    logic [DATA_WIDTH-1:0] s1_rdata;

    rsp_t                  fifo_mem [RSP_DEPTH];
    logic [PTR_W-1:0]      wptr;
    logic [PTR_W-1:0]      rptr;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W:0]        outstanding;
    logic                  push;
    logic                  pop;
    rsp_t                  rsp_in;
    rsp_t                  rsp_head;

    logic                  unused_a_param;
    assign unused_a_param = ^a_param;

    // Credit check uses registered state only, never d_ready.
    assign outstanding = (CNT_W+1)'(s1_valid) + (CNT_W+1)'(fifo_count);
    assign a_ready     = !reset && (outstanding < (CNT_W+1)'(RSP_DEPTH));
    assign accept      = a_valid && a_ready;

    // Request decode: opcode class, error conditions and word index.
    always_comb begin
        op_put     = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PART);
        op_get     = (a_opcode == OP_GET);
        offset     = a_address - BASE_ADDR;
        align_mask = OFF_W'((32'd1 << a_size) - 32'd1);
        word_idx   = IDX_W'(offset >> OFF_W);
        req_err    = 1'b0;
        if (!(op_put || op_get))
            req_err = 1'b1;
        if (a_size > SIZE_WIDTH'(OFF_W))
            req_err = 1'b1;
        if (|(a_address[OFF_W-1:0] & align_mask))
            req_err = 1'b1;
        if ((a_address < BASE_ADDR) || (offset >= MEM_BYTES))
            req_err = 1'b1;
    end

    // SRAM port: byte-masked write and full-word read at the accept edge.
    always_ff @(posedge clk) begin
        if (accept && op_put && !req_err) begin
            for (int b = 0; b < int'(MASK_WIDTH); b++) begin
                if (a_mask[b])
                    mem[word_idx][b*8 +: 8] <= a_data[b*8 +: 8];
            end
        end
        if (accept)
            s1_rdata <= mem[word_idx];
    end

    // Stage s1: request attributes captured alongside the SRAM read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_get    <= 1'b0;
            s1_err    <= 1'b0;
            s1_size   <= '0;
            s1_source <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_get    <= op_get;
                s1_err    <= req_err;
                s1_size   <= a_size;
                s1_source <= a_source;
            end
        end
    end

    // Response formation from s1; data only for an error-free Get.
    always_comb begin
        rsp_in        = '0;
        rsp_in.size   = s1_size;
        rsp_in.source = s1_source;
        rsp_in.error  = s1_err;
        if (s1_get && !s1_err) begin
            rsp_in.opcode = 3'd1;
            rsp_in.data   = s1_rdata;
        end
    end

    assign push     = s1_valid;
    assign pop      = d_valid && d_ready;
    assign rsp_head = fifo_mem[rptr];

    // Response FIFO; the credit check keeps pushes from ever finding it full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(RSP_DEPTH); i++)
                fifo_mem[i] <= '0;
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                fifo_mem[wptr] <= rsp_in;
                wptr <= (wptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : wptr + PTR_W'(1);
            end
            if (pop)
                rptr <= (rptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : rptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Saturating count of accepted errored requests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_count <= '0;
        else if (accept && req_err && (err_count != 16'hFFFF))
            err_count <= err_count + 16'd1;
    end

    assign d_valid  = (fifo_count != '0);
    assign d_opcode = rsp_head.opcode;
    assign d_param  = 3'd0;
    assign d_size   = rsp_head.size;
    assign d_source = rsp_head.source;
    assign d_sink   = '0;
    assign d_data   = rsp_head.data;
    assign d_error  = rsp_head.error;

endmodule

// File: tb/tb_tl_ul_sram_slave.sv
// Bench for tl_ul_sram_slave: vector table plus hand sequences, with a
// scoreboard queue filled on Channel A accepts and drained on Channel D pops.
module tb_tl_ul_sram_slave;

    logic        clk;
    logic        reset;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic [1:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [2:0]  d_size;
    logic [1:0]  d_source;
    logic [0:0]  d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic [15:0] err_count;

    tl_ul_sram_slave dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
        .a_data(a_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
        .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_data(d_data),
        .d_error(d_error), .err_count(err_count)
    );

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  size;
        logic [1:0]  src;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        logic [2:0]  e_op;
        logic        e_err;
        logic [31:0] e_data;
    } vec_t;

    typedef struct {
        logic [2:0]  op;
        logic        err;
        logic [31:0] data;
        logic [2:0]  size;
        logic [1:0]  src;
        int          acc_cyc;
        bit          chk_lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur_exp;
    exp_t        mon_e;
    vec_t        tbl[14];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    bit          stalled = 0;
    logic [40:0] held;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on response, watch stall stability.
    always @(negedge clk) begin
        if (!reset) begin
            if (a_valid && a_ready) begin
                mon_e = cur_exp;
                mon_e.acc_cyc = cyc;
                sb.push_back(mon_e);
            end
            if (d_valid && d_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: source %0d with empty scoreboard (cycle %0d)", d_source, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("d_opcode", 64'(d_opcode), 64'(mon_e.op));
                    chk("d_error",  64'(d_error),  64'(mon_e.err));
                    chk("d_data",   64'(d_data),   64'(mon_e.data));
                    chk("d_size",   64'(d_size),   64'(mon_e.size));
                    chk("d_source", 64'(d_source), 64'(mon_e.src));
                    chk("d_param_sink", 64'({d_param, d_sink}), 64'(0));
                    if (mon_e.chk_lat)
                        chk("latency", 64'(cyc - mon_e.acc_cyc), 64'(2));
                end
            end
            if (d_valid && !d_ready) begin
                if (stalled)
                    chk("d_stable", 64'({d_opcode, d_size, d_source, d_data, d_error}), 64'(held));
                held    = {d_opcode, d_size, d_source, d_data, d_error};
                stalled = 1'b1;
            end else begin
                stalled = 1'b0;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic drive(input logic [2:0] op, input logic [2:0] size, input logic [1:0] src,
                         input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                         input logic [2:0] e_op, input logic e_err, input logic [31:0] e_data,
                         input bit lat);
        a_valid   = 1'b1;
        a_opcode  = op;
        a_size    = size;
        a_source  = src;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
        cur_exp.op      = e_op;
        cur_exp.err     = e_err;
        cur_exp.data    = e_data;
        cur_exp.size    = size;
        cur_exp.src     = src;
        cur_exp.acc_cyc = 0;
        cur_exp.chk_lat = lat;
    endtask

    // Wait (bounded) for the driven request to be accepted, then step past the edge.
    task automatic wait_accept(input string name);
        bit ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (a_ready) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: accept timeout, a_ready=%0b", name, a_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        bit ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && !d_valid) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: drain timeout, %0d responses outstanding", name, sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc;
        logic [1:0] s;

        //          op    size  src   addr           mask  data           e_op  err   e_data
        tbl[0]  = '{3'd0, 3'd2, 2'd2, 32'h0000_0010, 4'hF, 32'hDEADBEEF, 3'd0, 1'b0, 32'h0};
        tbl[1]  = '{3'd4, 3'd2, 2'd1, 32'h0000_0010, 4'hF, 32'h0,        3'd1, 1'b0, 32'hDEADBEEF};
        tbl[2]  = '{3'd1, 3'd2, 2'd0, 32'h0000_0010, 4'h2, 32'h0000AA00, 3'd0, 1'b0, 32'h0};
        tbl[3]  = '{3'd4, 3'd2, 2'd3, 32'h0000_0010, 4'h0, 32'h0,        3'd1, 1'b0, 32'hDEADAAEF};
        tbl[4]  = '{3'd4, 3'd2, 2'd0, 32'h0000_1000, 4'hF, 32'h0,        3'd0, 1'b1, 32'h0};
        tbl[5]  = '{3'd6, 3'd2, 2'd1, 32'h0000_0010, 4'hF, 32'h0,        3'd0, 1'b1, 32'h0};
        tbl[6]  = '{3'd0, 3'd3, 2'd2, 32'h0000_0010, 4'hF, 32'hFFFFFFFF, 3'd0, 1'b1, 32'h0};
        tbl[7]  = '{3'd0, 3'd2, 2'd3, 32'h0000_0012, 4'hF, 32'h11111111, 3'd0, 1'b1, 32'h0};
        tbl[8]  = '{3'd4, 3'd2, 2'd0, 32'h0000_0010, 4'hF, 32'h0,        3'd1, 1'b0, 32'hDEADAAEF};
        tbl[9]  = '{3'd1, 3'd0, 2'd1, 32'h0000_0013, 4'h8, 32'h77000000, 3'd0, 1'b0, 32'h0};
        tbl[10] = '{3'd4, 3'd1, 2'd2, 32'h0000_0012, 4'hF, 32'h0,        3'd1, 1'b0, 32'h77ADAAEF};
        tbl[11] = '{3'd0, 3'd2, 2'd3, 32'h0000_0FFC, 4'hF, 32'hCAFEF00D, 3'd0, 1'b0, 32'h0};
        tbl[12] = '{3'd4, 3'd2, 2'd0, 32'h0000_0FFC, 4'hF, 32'h0,        3'd1, 1'b0, 32'hCAFEF00D};
        tbl[13] = '{3'd4, 3'd0, 2'd1, 32'h0000_0FFF, 4'hF, 32'h0,        3'd1, 1'b0, 32'hCAFEF00D};

        reset = 1'b1; a_valid = 1'b0; a_opcode = '0; a_param = '0; a_size = '0;
        a_source = '0; a_address = '0; a_mask = '0; a_data = '0; d_ready = 1'b1;
        cur_exp = '{3'd0, 1'b0, 32'h0, 3'd0, 2'd0, 0, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_ready",   64'(a_ready),   64'(0));
        chk("rst_d_valid",   64'(d_valid),   64'(0));
        chk("rst_err_count", 64'(err_count), 64'(0));
        chk("rst_d_fields",  64'({d_opcode, d_size, d_source, d_data, d_error}), 64'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("a_ready_after_reset", 64'(a_ready), 64'(1));
        @(posedge clk);
        #1;

        // Vector table, back to back with d_ready high
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].op, tbl[i].size, tbl[i].src, tbl[i].addr, tbl[i].mask, tbl[i].data,
                  tbl[i].e_op, tbl[i].e_err, tbl[i].e_data, 1'b1);
            wait_accept($sformatf("vec%0d", i));
        end
        a_valid = 1'b0;
        drain("table_drain");
        chk("err_count_after_errors", 64'(err_count), 64'(4));

        // Backpressure: exactly RSP_DEPTH accepts with d_ready low
        d_ready = 1'b0;
        s = 2'd0;
        acc = 0;
        drive(3'd4, 3'd2, s, 32'h10, 4'hF, 32'h0, 3'd1, 1'b0, 32'h77ADAAEF, 1'b0);
        for (int n = 0; n < 8; n++) begin
            bit took;
            @(negedge clk);
            took = a_ready;
            if (took) acc++;
            @(posedge clk);
            #1;
            if (took) begin
                s = (s == 2'd2) ? 2'd0 : s + 2'd1;
                drive(3'd4, 3'd2, s, 32'h10, 4'hF, 32'h0, 3'd1, 1'b0, 32'h77ADAAEF, 1'b0);
            end
        end
        chk("bp_accepts", 64'(acc), 64'(3));
        d_ready = 1'b1;
        @(negedge clk);
        chk("bp_a_ready_before_pop", 64'(a_ready), 64'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_a_ready_after_pop", 64'(a_ready), 64'(1));
        @(posedge clk);
        #1;
        drive(3'd4, 3'd2, 2'd1, 32'h10, 4'hF, 32'h0, 3'd1, 1'b0, 32'h77ADAAEF, 1'b0);
        wait_accept("bp_resume1");
        drive(3'd4, 3'd2, 2'd2, 32'hFFC, 4'hF, 32'h0, 3'd1, 1'b0, 32'hCAFEF00D, 1'b0);
        wait_accept("bp_resume2");
        a_valid = 1'b0;
        drain("bp_drain");

        // Throughput: 8 back-to-back Gets, each accepted on consecutive cycles
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0)
                drive(3'd4, 3'd2, 2'(i), 32'h10, 4'hF, 32'h0, 3'd1, 1'b0, 32'h77ADAAEF, 1'b1);
            else
                drive(3'd4, 3'd2, 2'(i), 32'hFFC, 4'hF, 32'h0, 3'd1, 1'b0, 32'hCAFEF00D, 1'b1);
            @(negedge clk);
            chk($sformatf("tput_accept%0d", i), 64'(a_ready), 64'(1));
            @(posedge clk);
            #1;
        end
        a_valid = 1'b0;
        drain("tput_drain");

        // Reset mid-burst
        for (int i = 0; i < 3; i++) begin
            drive(3'd4, 3'd2, 2'(i), 32'h10, 4'hF, 32'h0, 3'd1, 1'b0, 32'h77ADAAEF, 1'b1);
            wait_accept($sformatf("burst%0d", i));
        end
        chk("pre_rst_d_valid", 64'(d_valid), 64'(1));
        reset = 1'b1;
        a_valid = 1'b0;
        #1;
        chk("midrst_d_valid",   64'(d_valid),   64'(0));
        chk("midrst_a_ready",   64'(a_ready),   64'(0));
        chk("midrst_err_count", 64'(err_count), 64'(0));
        sb.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            chk("no_stale_rsp", 64'(d_valid), 64'(0));
        end
        @(posedge clk);
        #1;
        drive(3'd4, 3'd2, 2'd3, 32'h10, 4'hF, 32'h0, 3'd1, 1'b0, 32'h77ADAAEF, 1'b1);
        wait_accept("post_rst_get");
        a_valid = 1'b0;
        drain("post_rst_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
